// File: rtl/mem_pkg.sv
// Shared types and default I/O addresses for the CPU memory responder.
package mem_pkg;
  typedef enum logic [1:0] {MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b10} mem_cmd_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

  localparam logic [8:0] DEF_SW_ADDR  = 9'h140;
  localparam logic [8:0] DEF_LED_ADDR = 9'h100;
  localparam int         CNT_W        = 4;
endpackage

// File: rtl/mem_array.sv
// Word RAM: synchronous write with enable, combinational read, contents not reset.
module mem_array #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder: RAM plus switch/LED registers, fixed LATENCY.
// resp_valid rises LATENCY edges after accept; side effects commit on the edge leaving RESP.
module mem_responder
  import mem_pkg::*;
#(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                LATENCY  = 2,
  parameter logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(DEF_SW_ADDR),
  parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(DEF_LED_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] read_data,
  output logic              resp_err,
  input  logic [7:0]        sw,
  output logic [7:0]        led
);
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be within 1..15");
  end

  resp_state_t       state;
  logic [CNT_W-1:0]  cnt;
  mem_cmd_t          cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_next;
  logic              accept, is_ram, is_sw, is_led, led_wr, bad, ram_we;

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid && (mem_cmd == MREAD || mem_cmd == MWRITE);

  assign is_ram = !addr_q[ADDR_W-1];
  assign is_sw  = (addr_q == SW_ADDR);
  assign is_led = (addr_q == LED_ADDR);
  assign led_wr = (cmd_q == MWRITE) && is_led;
  assign bad    = !is_ram && !(((cmd_q == MREAD) && is_sw) || led_wr);
  // Keyed on state so an async reset during RESP also blocks the RAM write.
  assign ram_we = (state == RESP) && (cmd_q == MWRITE) && is_ram;

  always_comb begin
    rd_next = '0;
    if (!bad && cmd_q == MREAD) rd_next = is_ram ? ram_rdata : DATA_W'(sw);
  end

  mem_array #(.AW(ADDR_W-1), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q[ADDR_W-2:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd_q      <= MNONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      read_data  <= '0;
      resp_err   <= 1'b0;
      led        <= 8'h00;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q   <= mem_cmd_t'(mem_cmd);
            addr_q  <= mem_addr;
            wdata_q <= write_data;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          read_data  <= rd_next;
          resp_err   <= bad;
          if (led_wr) led <= wdata_q[7:0];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 1, 5) against a behavioural model.
module tb_mem_responder;
  localparam int NI = 3;
  localparam logic [1:0] C_NONE = 2'd0, C_READ = 2'd1, C_WRITE = 2'd2, C_RSVD = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic [1:0]  mem_cmd [NI];
  logic [8:0]  mem_addr [NI];
  logic [15:0] write_data [NI];
  logic        resp_valid [NI];
  logic [15:0] read_data [NI];
  logic        resp_err [NI];
  logic [7:0]  sw [NI];
  logic [7:0]  led [NI];

  int checks = 0;
  int failures = 0;

  logic [15:0] ram_m [NI][256];
  logic [7:0]  led_m [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    mem_responder #(.ADDR_W(9), .DATA_W(16), .LATENCY(L)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .mem_cmd    (mem_cmd[g]),
      .mem_addr   (mem_addr[g]),
      .write_data (write_data[g]),
      .resp_valid (resp_valid[g]),
      .read_data  (read_data[g]),
      .resp_err   (resp_err[g]),
      .sw         (sw[g]),
      .led        (led[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  // Reference: decode rules applied directly to address and command.
  task automatic model(input int k, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] data, input logic [7:0] swv,
                       output logic [15:0] erd, output logic eerr);
    erd = 16'h0;
    eerr = 1'b0;
    if (addr < 9'h100) begin
      if (cmd == C_READ) erd = ram_m[k][addr[7:0]];
      else ram_m[k][addr[7:0]] = data;
    end else if (cmd == C_READ && addr == 9'h140) begin
      erd = {8'h00, swv};
    end else if (cmd == C_WRITE && addr == 9'h100) begin
      led_m[k] = data[7:0];
    end else begin
      eerr = 1'b1;
    end
  endtask

  task automatic do_req(input int k, input logic [1:0] cmd, input logic [8:0] addr,
                        input logic [15:0] data, output logic [15:0] rd, output logic err);
    int n = 0;
    int lat = 0;
    @(negedge clk);
    mem_cmd[k] = cmd; mem_addr[k] = addr; write_data[k] = data; req_valid[k] = 1'b1;
    while (!req_ready[k] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("accept_timeout", k, 0, 1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0; mem_cmd[k] = C_NONE;
    while (!resp_valid[k] && lat < 50) begin @(posedge clk); #1; lat++; end
    check("latency", k, lat, lat_of(k));
    rd = read_data[k];
    err = resp_err[k];
    @(posedge clk); #1;
    check("pulse_width", k, resp_valid[k], 0);
  endtask

  task automatic txn(input int k, input logic [1:0] cmd, input logic [8:0] addr,
                     input logic [15:0] data, input logic [7:0] swv);
    logic [15:0] erd, ard;
    logic eerr, aerr;
    sw[k] = swv;
    model(k, cmd, addr, data, swv, erd, eerr);
    do_req(k, cmd, addr, data, ard, aerr);
    check("read_data", k, ard, erd);
    check("resp_err", k, aerr, eerr);
    check("led", k, led[k], led_m[k]);
  endtask

  task automatic hold_test(input int k);
    int L = lat_of(k);
    int t = 0, r1 = -1, r2 = -1, pulses = 0, busy_ready = 0;
    logic [15:0] rd2 = 16'h0;
    @(negedge clk);
    mem_cmd[k] = C_READ; mem_addr[k] = 9'h003; req_valid[k] = 1'b1;
    @(posedge clk); #1;
    check("busy_ready", k, req_ready[k], 0);
    while (r2 < 0 && t < 60) begin
      @(posedge clk); #1; t++;
      if (t < L && req_ready[k]) busy_ready++;
      if (resp_valid[k]) begin
        pulses++;
        if (r1 < 0) r1 = t;
        else begin r2 = t; rd2 = read_data[k]; end
      end
    end
    req_valid[k] = 1'b0; mem_cmd[k] = C_NONE;
    check("hold_first_resp", k, r1, L);
    check("hold_period", k, r2 - r1, L + 1);
    check("hold_pulses", k, pulses, 2);
    check("hold_busy_ready", k, busy_ready, 0);
    check("hold_read_data", k, rd2, ram_m[k][3]);
  endtask

  task automatic no_accept_test(input int k, input logic [1:0] cmd);
    int bad = 0;
    @(negedge clk);
    mem_cmd[k] = cmd; mem_addr[k] = 9'h003; req_valid[k] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (resp_valid[k] || !req_ready[k]) bad++;
    end
    req_valid[k] = 1'b0; mem_cmd[k] = C_NONE;
    check("no_accept", k, bad, 0);
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] data;
    logic [7:0]  swv;
    logic [15:0] rd;
    logic        err;
    logic [7:0]  led;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [15:0] ard, erd;
    logic aerr, eerr;
    int seen;

    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0; mem_cmd[k] = C_NONE; mem_addr[k] = '0;
      write_data[k] = '0; sw[k] = '0; led_m[k] = 8'h00;
    end

    vt[0] = '{C_WRITE, 9'h0A2, 16'h1234, 8'h00, 16'h0000, 1'b0, 8'h00};
    vt[1] = '{C_READ,  9'h0A2, 16'h0000, 8'h00, 16'h1234, 1'b0, 8'h00};
    vt[2] = '{C_WRITE, 9'h100, 16'hFFA5, 8'h00, 16'h0000, 1'b0, 8'hA5};
    vt[3] = '{C_READ,  9'h140, 16'h0000, 8'h3C, 16'h003C, 1'b0, 8'hA5};
    vt[4] = '{C_READ,  9'h1FF, 16'h0000, 8'h3C, 16'h0000, 1'b1, 8'hA5};
    vt[5] = '{C_WRITE, 9'h140, 16'h0077, 8'h3C, 16'h0000, 1'b1, 8'hA5};
    vt[6] = '{C_READ,  9'h100, 16'h0000, 8'h3C, 16'h0000, 1'b1, 8'hA5};
    vt[7] = '{C_WRITE, 9'h0FF, 16'h00FF, 8'h00, 16'h0000, 1'b0, 8'hA5};
    vt[8] = '{C_READ,  9'h0FF, 16'h0000, 8'h00, 16'h00FF, 1'b0, 8'hA5};

    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_req_ready", k, req_ready[k], 1);
      check("rst_resp_valid", k, resp_valid[k], 0);
      check("rst_read_data", k, read_data[k], 0);
      check("rst_resp_err", k, resp_err[k], 0);
      check("rst_led", k, led[k], 0);
    end
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      sw[0] = vt[i].swv;
      model(0, vt[i].cmd, vt[i].addr, vt[i].data, vt[i].swv, erd, eerr);
      do_req(0, vt[i].cmd, vt[i].addr, vt[i].data, ard, aerr);
      check("vec_read_data", i, ard, vt[i].rd);
      check("vec_resp_err", i, aerr, vt[i].err);
      check("vec_led", i, led[0], vt[i].led);
    end

    // Reset mid-WAIT must drop the pending write.
    txn(0, C_WRITE, 9'h005, 16'h0000, 8'h00);
    @(negedge clk);
    mem_cmd[0] = C_WRITE; mem_addr[0] = 9'h005; write_data[0] = 16'hBEEF; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; mem_cmd[0] = C_NONE;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid[0]) seen++;
      if (i == 1) reset = 1'b0;
    end
    for (int k = 0; k < NI; k++) led_m[k] = 8'h00;
    check("abort_no_resp", 0, seen, 0);
    check("abort_req_ready", 0, req_ready[0], 1);
    check("abort_led", 0, led[0], 0);
    txn(0, C_READ, 9'h005, 16'h0000, 8'h00);

    for (int k = 0; k < NI; k++) begin
      for (int a = 0; a < 16; a++) txn(k, C_WRITE, 9'(a), 16'($urandom), 8'h00);
      hold_test(k);
      no_accept_test(k, C_NONE);
      no_accept_test(k, C_RSVD);
      for (int i = 0; i < 40; i++) begin
        int sel = $urandom_range(0, 9);
        logic [8:0] addr;
        if (sel < 6) addr = 9'($urandom_range(0, 15));
        else if (sel == 6) addr = 9'h100;
        else if (sel == 7 || sel == 9) addr = 9'h140;
        else addr = 9'h100 | 9'($urandom_range(0, 255));
        txn(k, 2'($urandom_range(1, 2)), addr, 16'($urandom), 8'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
